// File: rtl/tetris_pkg.sv
// Shared Tetris constants: game key codes, PS/2 scan codes and the scan-code to key map.
package tetris_pkg;

    localparam logic [1:0] KEY_UP    = 2'b00;
    localparam logic [1:0] KEY_LEFT  = 2'b01;
    localparam logic [1:0] KEY_RIGHT = 2'b10;
    localparam logic [1:0] KEY_ENTER = 2'b11;

    localparam logic [7:0] SC_E0        = 8'hE0;
    localparam logic [7:0] SC_F0        = 8'hF0;
    localparam logic [7:0] SC_UP_EXT    = 8'h75;
    localparam logic [7:0] SC_W         = 8'h1D;
    localparam logic [7:0] SC_LEFT_EXT  = 8'h6B;
    localparam logic [7:0] SC_A         = 8'h1C;
    localparam logic [7:0] SC_RIGHT_EXT = 8'h74;
    localparam logic [7:0] SC_D         = 8'h23;
    localparam logic [7:0] SC_ENTER     = 8'h5A;

    typedef struct packed {
        logic       hit;
        logic [1:0] code;
    } key_map_t;

    // Enter is accepted with or without the E0 prefix (main and keypad Enter).
    function automatic key_map_t map_scan(input logic ext, input logic [7:0] sc);
        key_map_t m;
        m.hit  = 1'b1;
        m.code = KEY_UP;
        if (sc == SC_ENTER)                   m.code = KEY_ENTER;
        else if (ext && sc == SC_UP_EXT)      m.code = KEY_UP;
        else if (ext && sc == SC_LEFT_EXT)    m.code = KEY_LEFT;
        else if (ext && sc == SC_RIGHT_EXT)   m.code = KEY_RIGHT;
        else if (!ext && sc == SC_W)          m.code = KEY_UP;
        else if (!ext && sc == SC_A)          m.code = KEY_LEFT;
        else if (!ext && sc == SC_D)          m.code = KEY_RIGHT;
        else                                  m.hit  = 1'b0;
        return m;
    endfunction

endpackage

// File: rtl/ps2_key_decoder_if.sv
// PS/2 pins in, game key events out; slave is the decoder side.
interface ps2_key_decoder_if;
    logic       ps2_clk;
    logic       ps2_data;
    logic [1:0] key_code;
    logic       key_valid;
    logic [3:0] key_held;
    logic       frame_err;

    modport master (output ps2_clk, ps2_data,
                    input  key_code, key_valid, key_held, frame_err);
    modport slave  (input  ps2_clk, ps2_data,
                    output key_code, key_valid, key_held, frame_err);
endinterface

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: pin synchronizers, falling-edge sampling, frame check and timeout.
module ps2_rx #(
    parameter int TIMEOUT_CYC = 200_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       rx_err
);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic [2:0]    clk_sync;
    logic [1:0]    data_sync;
    logic [3:0]    bit_cnt;
    logic [TW-1:0] tcnt;
    logic [9:0]    shift;
    logic [10:0]   frame;
    logic          fall;
    logic          last_bit;
    logic          timeout;
    logic          frame_ok;

    // Stage p0: synchronize pins; clk_sync[2] is the previous synced sample for edge detect
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync  <= 3'b111;
            data_sync <= 2'b11;
        end else begin
            clk_sync  <= {clk_sync[1:0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
        end
    end

    assign fall     = clk_sync[2] & ~clk_sync[1];
    assign last_bit = fall && (bit_cnt == 4'd10);
    // An edge in the same cycle wins over an expiring timeout.
    assign timeout  = !fall && (bit_cnt != 4'd0) && (tcnt == TW'(TIMEOUT_CYC - 1));

    // Frame as seen including the stop bit arriving this cycle: {stop, parity, d7..d0, start}
    assign frame    = {data_sync[1], shift};
    assign frame_ok = ~frame[0] & frame[10] & (^frame[9:1]);
    assign rx_byte  = frame[8:1];
    assign rx_valid = last_bit & frame_ok;
    assign rx_err   = (last_bit & ~frame_ok) | timeout;

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt <= 4'd0;
            tcnt    <= '0;
        end else if (fall) begin
            tcnt    <= '0;
            bit_cnt <= (bit_cnt == 4'd10) ? 4'd0 : bit_cnt + 4'd1;
        end else if (bit_cnt != 4'd0) begin
            if (timeout) begin
                bit_cnt <= 4'd0;
                tcnt    <= '0;
            end else begin
                tcnt <= tcnt + 1'b1;
            end
        end else begin
            tcnt <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (fall) shift <= {data_sync[1], shift[9:1]};
    end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard to Tetris key events: prefix tracking, key map, held state, auto-repeat filter.
module ps2_key_decoder
    import tetris_pkg::*;
#(
    parameter int TIMEOUT_CYC = 200_000,
    parameter bit REPEAT_EN   = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    ps2_key_decoder_if.slave    bus
);
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       rx_err;
    logic       ext;
    logic       brk;
    logic [1:0] code_p1;
    logic       valid_p1;
    logic [3:0] held_p1;
    logic       err_p1;
    key_map_t   hit;

    ps2_rx #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_rx (
        .clk      (clk),
        .rst      (rst),
        .ps2_clk  (bus.ps2_clk),
        .ps2_data (bus.ps2_data),
        .rx_byte  (rx_byte),
        .rx_valid (rx_valid),
        .rx_err   (rx_err)
    );

    assign hit = map_scan(ext, rx_byte);

    // Stage p1: decode byte, update held state and register the one-cycle strobes
    always_ff @(posedge clk) begin
        if (rst) begin
            ext      <= 1'b0;
            brk      <= 1'b0;
            code_p1  <= KEY_UP;
            valid_p1 <= 1'b0;
            held_p1  <= 4'b0000;
            err_p1   <= 1'b0;
        end else begin
            valid_p1 <= 1'b0;
            err_p1   <= rx_err;
            if (rx_err) begin
                ext <= 1'b0;
                brk <= 1'b0;
            end else if (rx_valid) begin
                if (rx_byte == SC_E0) begin
                    ext <= 1'b1;
                end else if (rx_byte == SC_F0) begin
                    brk <= 1'b1;
                end else begin
                    ext <= 1'b0;
                    brk <= 1'b0;
                    if (hit.hit) begin
                        if (brk) begin
                            held_p1[hit.code] <= 1'b0;
                        end else begin
                            held_p1[hit.code] <= 1'b1;
                            if (REPEAT_EN || !held_p1[hit.code]) begin
                                valid_p1 <= 1'b1;
                                code_p1  <= hit.code;
                            end
                        end
                    end
                end
            end
        end
    end

    assign bus.key_code  = code_p1;
    assign bus.key_valid = valid_p1;
    assign bus.key_held  = held_p1;
    assign bus.frame_err = err_p1;

endmodule

// File: doc/ps2_key_decoder.md
# ps2_key_decoder

Converts the raw PS/2 keyboard clock/data pins into one-cycle game key events consumed by the Tetris control block on its `keyboard_signal` input. It receives and validates 11-bit PS/2 frames and tracks the E0/F0 prefixes. It maps the four game keys to 2-bit codes and suppresses typematic auto-repeat, so each physical press yields exactly one event.

## Interface
- `TIMEOUT_CYC`, default 200_000: clk cycles without a PS/2 falling edge before a partial frame is discarded (2 ms at 100 MHz).
- `REPEAT_EN`, default 0: 1 passes typematic repeats through as events; 0 emits an event only on a released→pressed transition.
- `clk`  in  1  system clock.
- `rst`  in  1  reset, synchronous, active-high.
- `ps2_clk`  in  1  raw PS/2 clock pin, asynchronous.
- `ps2_data`  in  1  raw PS/2 data pin, asynchronous.
- `key_code`  out  2  00 up, 01 left, 10 right, 11 enter; valid only while `key_valid` is high.
- `key_valid`  out  1  one-cycle event strobe.
- `key_held`  out  4  per-key pressed state, bit index = `key_code`.
- `frame_err`  out  1  one-cycle pulse on a parity, start, stop or timeout error.

## Operation
- Reset values:
  - `key_code`=00, `key_valid`=0, `key_held`=0000, `frame_err`=0.
  - Bit counter=0, prefix flags cleared, synchronizers set to 1 (idle bus).
- Pins pass through 2-FF synchronizers. A falling edge is a synced sample of 1 followed by 0.
- Each falling edge samples `ps2_data` into an 11-bit shift register, LSB first: start, d0..d7, parity, stop. The counter runs 0..10.
- On the 11th bit the frame is valid iff start=0, stop=1 and d0..d7 plus parity has odd weight.
  - Valid frame: the byte goes to the decode stage.
  - Invalid frame: the byte is dropped, `frame_err` pulses and the prefix flags clear.
- Timeout:
  - The timeout counter runs only while the bit counter ≠ 0 and clears on every falling edge.
  - Reaching `TIMEOUT_CYC` zeroes the bit counter, clears the prefix flags and pulses `frame_err`.
- Decode stage, per byte:
  - E0 sets `ext`.
  - F0 sets `brk`.
  - Any other byte is looked up using `ext`, then `ext` and `brk` both clear.
- Map:
  - Up: ext 75 or non-ext 1D (W).
  - Left: ext 6B or non-ext 1C (A).
  - Right: ext 74 or non-ext 23 (D).
  - Enter: 5A with or without ext.
  - Every other byte is unmapped: no event and no held change.
- Make (brk=0): `key_held[k]` is set. An event fires if `REPEAT_EN`=1 or `key_held[k]` was 0.
- Break (brk=1): `key_held[k]` clears and no event fires.
- Aliases (W and up arrow, for example) share one held bit. A break of either alias clears it.

## Timing
- Let N be the clk cycle in which the synced falling edge of the stop bit is detected.
  - `key_valid`/`key_code` or `frame_err` is registered high in cycle N+1, for exactly one cycle.
  - `key_held` updates in the same cycle N+1.
- `key_code` holds its last value after the strobe.
- `key_valid` and `frame_err` are never high in the same cycle.
- A PS/2 bit period (≥60 µs) is far longer than the pipeline, so consecutive bytes never overlap in decode.
- `rst` mid-frame discards the partial frame and prefixes. The first complete frame after reset decodes normally.
- A timeout and a falling edge in the same cycle resolve to the edge: it is sampled and the timeout counter clears.

## Structure
- Shared package `tetris_pkg`:
  - `KEY_UP`/`KEY_LEFT`/`KEY_RIGHT`/`KEY_ENTER` 2-bit constants, also used by the game control block.
  - Scan-code constants `SC_E0`, `SC_F0` and the mapped codes.
- Sub-module `ps2_rx` contains the synchronizers, edge detect, shift register, parity check and timeout. Its outputs are `rx_byte[7:0]`, `rx_valid` and `rx_err`.
- The top `ps2_key_decoder` holds the prefix flags, the map, held tracking and the output registers.

## Test plan
- Frame 0x5A with correct odd parity → one `key_valid`, `key_code`=11, `key_held`=1000, N+1 latency.
- Bytes E0 6B, E0 6B, E0 F0 6B with `REPEAT_EN`=0 → exactly one event (01). `key_held[1]` sets and then clears.
- Same sequence with `REPEAT_EN`=1 → two events with code 01.
- Frame 0x1D with the parity bit flipped → `frame_err` pulse, no event. A following valid 0x1D → event 00.
- 5 bits, then a 2 ms idle, then a full frame 0x23 → timeout `frame_err`, then event 10.
- E0 followed by 0x75 with `rst` asserted between them → no event.
- Unmapped 0x15 → no event, `key_held` unchanged.
